// File: rtl/seq_detect_fsm_if.sv
// Serial bit stream in, registered detection status out, between a source and seq_detect_fsm.
// The source drives clear/in_valid/in; the detector drives match/match_cnt/fill.
interface seq_detect_fsm_if #(
  parameter int CNT_W  = 8,
  parameter int FILL_W = 3
);
  logic              clear;
  logic              in_valid;
  logic              in;
  logic              match;
  logic [CNT_W-1:0]  match_cnt;
  logic [FILL_W-1:0] fill;

  modport master (
    output clear, in_valid, in,
    input  match, match_cnt, fill
  );

  modport slave (
    input  clear, in_valid, in,
    output match, match_cnt, fill
  );
endinterface

// File: rtl/seq_detect_fsm.sv
// Serial pattern detector: match pulses one edge after the final pattern bit; saturating hit counter.
// No backpressure: a bit is consumed on every edge where in_valid is high; idle edges hold history.
module seq_detect_fsm #(
  parameter int                   PATTERN_W = 4,
  parameter logic [PATTERN_W-1:0] PATTERN   = 4'b1011,
  parameter int                   OVERLAP   = 1,
  parameter int                   CNT_W     = 8,
  localparam int                  FILL_W    = $clog2(PATTERN_W + 1)
) (
  input  logic            clk,
  input  logic            reset,
  seq_detect_fsm_if.slave bus
);

  typedef enum logic {FILLING, ARMED} state_t;

  localparam logic [FILL_W-1:0] FULL = FILL_W'(PATTERN_W);

  state_t                 state_q, state_d;
  logic [PATTERN_W-1:0]   hist_q, hist_d, hist_n;
  logic [FILL_W-1:0]      fill_q, fill_d, fill_n;
  logic                   match_q, match_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FILLING;
      hist_q  <= '0;
      fill_q  <= '0;
      match_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      match_q <= match_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    match_d = 1'b0;
    cnt_d   = cnt_q;
    hit     = 1'b0;
    hist_n  = {hist_q[PATTERN_W-2:0], bus.in};
    // Once ARMED the window stays full, so fill never needs to count past PATTERN_W.
    fill_n  = (state_q == ARMED) ? FULL : fill_q + 1'b1;

    if (bus.clear) begin
      state_d = FILLING;
      hist_d  = '0;
      fill_d  = '0;
      cnt_d   = '0;
    end else if (bus.in_valid) begin
      hist_d  = hist_n;
      hit     = (fill_n == FULL) && (hist_n == PATTERN);
      match_d = hit;
      if (hit) begin
        if (OVERLAP != 0) begin
          state_d = ARMED;
          fill_d  = FULL;
        end else begin
          state_d = FILLING;
          fill_d  = '0;
        end
        if (!(&cnt_q)) cnt_d = cnt_q + 1'b1;
      end else begin
        fill_d  = fill_n;
        state_d = (fill_n == FULL) ? ARMED : FILLING;
      end
    end
  end

  assign bus.match     = match_q;
  assign bus.match_cnt = cnt_q;
  assign bus.fill      = fill_q;

endmodule

// File: tb/tb_seq_detect_fsm.sv
// Directed bench for seq_detect_fsm: overlap, non-overlap, saturation/all-zero pattern,
// valid gaps, mid-sequence reset and clear collision, each with hand-computed expectations.
module tb_seq_detect_fsm;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Per-DUT drive registers: 0 = overlap, 1 = non-overlap, 2 = all-zero pattern / CNT_W=2
  logic [2:0] vld_r = '0;
  logic [2:0] bit_r = '0;
  logic [2:0] clr_r = '0;

  seq_detect_fsm_if #(.CNT_W(8), .FILL_W(3)) ov_if ();
  seq_detect_fsm_if #(.CNT_W(8), .FILL_W(3)) no_if ();
  seq_detect_fsm_if #(.CNT_W(2), .FILL_W(3)) sat_if ();

  assign ov_if.in_valid  = vld_r[0];
  assign ov_if.in        = bit_r[0];
  assign ov_if.clear     = clr_r[0];
  assign no_if.in_valid  = vld_r[1];
  assign no_if.in        = bit_r[1];
  assign no_if.clear     = clr_r[1];
  assign sat_if.in_valid = vld_r[2];
  assign sat_if.in       = bit_r[2];
  assign sat_if.clear    = clr_r[2];

  seq_detect_fsm #(.PATTERN_W(4), .PATTERN(4'b1011), .OVERLAP(1), .CNT_W(8))
    u_ov (.clk(clk), .reset(reset), .bus(ov_if.slave));
  seq_detect_fsm #(.PATTERN_W(4), .PATTERN(4'b1011), .OVERLAP(0), .CNT_W(8))
    u_no (.clk(clk), .reset(reset), .bus(no_if.slave));
  seq_detect_fsm #(.PATTERN_W(4), .PATTERN(4'b0000), .OVERLAP(1), .CNT_W(2))
    u_sat (.clk(clk), .reset(reset), .bus(sat_if.slave));

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Drive one edge on one DUT (others idle), return #1 after the edge.
  task automatic step(input int dut, input logic v, input logic b, input logic c);
    @(negedge clk);
    vld_r = '0; bit_r = '0; clr_r = '0;
    vld_r[dut] = v;
    bit_r[dut] = b;
    clr_r[dut] = c;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    vld_r = '0; bit_r = '0; clr_r = '0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  logic [6:0] s7;
  logic [6:0] m7;
  logic [3:0] s4;
  logic [7:0] msat;
  logic [7:0] cnt_sat [8];

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_ov_match", ov_if.match, 0);
    check("rst_ov_cnt", ov_if.match_cnt, 0);
    check("rst_ov_fill", ov_if.fill, 0);
    check("rst_sat_cnt", sat_if.match_cnt, 0);
    @(negedge clk);
    reset = 1'b0;

    // Overlapping detection of 1011 in 1011011
    s7 = 7'b1011011;
    m7 = 7'b0001001;
    for (int i = 6; i >= 0; i--) begin
      step(0, 1'b1, s7[i], 1'b0);
      check($sformatf("ov_match_b%0d", 7 - i), ov_if.match, m7[i]);
    end
    check("ov_cnt", ov_if.match_cnt, 2);
    check("ov_fill", ov_if.fill, 4);
    step(0, 1'b0, 1'b0, 1'b0);
    check("ov_idle_match", ov_if.match, 0);

    // Non-overlapping on the same stream
    m7 = 7'b0001000;
    for (int i = 6; i >= 0; i--) begin
      step(1, 1'b1, s7[i], 1'b0);
      check($sformatf("no_match_b%0d", 7 - i), no_if.match, m7[i]);
    end
    check("no_cnt", no_if.match_cnt, 1);
    check("no_fill", no_if.fill, 3);

    // Valid gaps: 3 idle cycles between each bit
    pulse_reset();
    s4 = 4'b1011;
    for (int i = 3; i >= 0; i--) begin
      step(0, 1'b1, s4[i], 1'b0);
      check($sformatf("gap_match_b%0d", 4 - i), ov_if.match, (i == 0) ? 1 : 0);
      for (int g = 0; g < 3; g++) begin
        step(0, 1'b0, 1'b1, 1'b0);
        check($sformatf("gap_idle_b%0d_%0d", 4 - i, g), ov_if.match, 0);
        check($sformatf("gap_fill_b%0d_%0d", 4 - i, g), ov_if.fill, 4 - i);
      end
    end
    check("gap_cnt", ov_if.match_cnt, 1);

    // Reset mid-sequence
    pulse_reset();
    step(0, 1'b1, 1'b1, 1'b0);
    step(0, 1'b1, 1'b0, 1'b0);
    step(0, 1'b1, 1'b1, 1'b0);
    check("mid_fill_pre", ov_if.fill, 3);
    pulse_reset();
    check("mid_fill_rst", ov_if.fill, 0);
    step(0, 1'b1, 1'b1, 1'b0);
    check("mid_match1", ov_if.match, 0);
    check("mid_fill1", ov_if.fill, 1);
    step(0, 1'b1, 1'b0, 1'b0);
    step(0, 1'b1, 1'b1, 1'b0);
    check("mid_match3", ov_if.match, 0);
    step(0, 1'b1, 1'b1, 1'b0);
    check("mid_match4", ov_if.match, 1);
    check("mid_cnt", ov_if.match_cnt, 1);

    // Saturation with all-zero pattern and fill guard
    pulse_reset();
    msat = 8'b00011111;
    cnt_sat = '{0, 0, 0, 1, 2, 3, 3, 3};
    for (int i = 0; i < 8; i++) begin
      step(2, 1'b1, 1'b0, 1'b0);
      check($sformatf("sat_match_b%0d", i + 1), sat_if.match, msat[7 - i]);
      check($sformatf("sat_cnt_b%0d", i + 1), sat_if.match_cnt, cnt_sat[i]);
    end
    step(2, 1'b0, 1'b0, 1'b0);
    check("sat_idle_match", sat_if.match, 0);
    check("sat_idle_cnt", sat_if.match_cnt, 3);

    // Clear collides with the final pattern bit
    pulse_reset();
    step(0, 1'b1, 1'b1, 1'b0);
    step(0, 1'b1, 1'b0, 1'b0);
    step(0, 1'b1, 1'b1, 1'b0);
    step(0, 1'b1, 1'b1, 1'b1);
    check("clr_match", ov_if.match, 0);
    check("clr_cnt", ov_if.match_cnt, 0);
    check("clr_fill", ov_if.fill, 0);
    // History must be gone: 0,1,1 alone cannot complete 1011
    step(0, 1'b1, 1'b0, 1'b0);
    step(0, 1'b1, 1'b1, 1'b0);
    step(0, 1'b1, 1'b1, 1'b0);
    check("clr_post_match", ov_if.match, 0);
    check("clr_post_fill", ov_if.fill, 3);

    // Clear on an idle edge also zeroes a nonzero counter
    step(0, 1'b1, 1'b1, 1'b0);
    step(0, 1'b1, 1'b0, 1'b0);
    step(0, 1'b1, 1'b1, 1'b0);
    step(0, 1'b1, 1'b1, 1'b0);
    check("clr2_match", ov_if.match, 1);
    step(0, 1'b0, 1'b0, 1'b1);
    check("clr2_cnt", ov_if.match_cnt, 0);
    check("clr2_fill", ov_if.fill, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
